// File: rtl/calc_pkg.sv
// Shared constants, FSM encoding and helpers for the calculator result path.
package calc_pkg;

  localparam int RES_W   = 32;
  localparam int NUM_DIG = 10;
  localparam int BCD_W   = 4 * NUM_DIG;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND_SIGN,
    ST_SEND_DIG,
    ST_SEND_CR,
    ST_SEND_LF
  } state_t;

  // Index of the most significant nonzero BCD digit; 0 when all digits are zero.
  function automatic logic [3:0] msd_index(input logic [BCD_W-1:0] bcd);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (bcd[i*4 +: 4] != 4'd0) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32 shift/adjust cycles after start, then a done pulse.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             done
);

  logic [RES_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       cnt;
  logic             run;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign bcd_adj[g*4 +: 4] = (bcd_out[g*4 +: 4] >= 4'd5) ? bcd_out[g*4 +: 4] + 4'd3
                                                           : bcd_out[g*4 +: 4];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bin_sr  <= '0;
      bcd_out <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr  <= bin_in;
        bcd_out <= '0;
        cnt     <= '0;
        run     <= 1'b1;
      end else if (run) begin
        bcd_out <= {bcd_adj[BCD_W-2:0], bin_sr[RES_W-1]};
        bin_sr  <= {bin_sr[RES_W-2:0], 1'b0};
        cnt     <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/res_ascii_tx.sv
// Captures an arithmetic result and streams it as decimal ASCII (sign, digits, CR LF)
// over a valid/ready byte interface.
module res_ascii_tx
  import calc_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter bit EOL    = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [RES_W-1:0] res_in,
  input  logic             res_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);

  state_t           state, state_d;
  logic [3:0]       ptr, ptr_d;
  logic             neg, neg_d;
  logic [7:0]       tx_data_d;
  logic             tx_valid_d;
  logic             start, conv_done, xfer;
  logic [RES_W-1:0] mag;
  logic [BCD_W-1:0] bcd;

  assign start = (state == ST_IDLE) && res_valid;
  assign xfer  = tx_valid && tx_ready;
  assign busy  = (state != ST_IDLE);
  // Two's-complement negate as unsigned, so 0x8000_0000 maps to 2147483648.
  assign mag   = (SIGNED && res_in[RES_W-1]) ? (~res_in + 32'd1) : res_in;

  bin2bcd_seq u_b2b (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .bin_in  (mag),
    .bcd_out (bcd),
    .done    (conv_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      ptr      <= 4'd0;
      neg      <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      neg      <= neg_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    neg_d   = neg;
    case (state)
      ST_IDLE: if (res_valid) begin
        state_d = ST_CONV;
        neg_d   = SIGNED && res_in[RES_W-1];
      end
      ST_CONV: if (conv_done) begin
        state_d = neg ? ST_SEND_SIGN : ST_SEND_DIG;
        ptr_d   = msd_index(bcd);
      end
      ST_SEND_SIGN: if (xfer) state_d = ST_SEND_DIG;
      ST_SEND_DIG: if (xfer) begin
        if (ptr == 4'd0) state_d = EOL ? ST_SEND_CR : ST_IDLE;
        else             ptr_d   = ptr - 4'd1;
      end
      ST_SEND_CR: if (xfer) state_d = ST_SEND_LF;
      ST_SEND_LF: if (xfer) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so a stalled byte holds.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    case (state_d)
      ST_SEND_SIGN: begin tx_valid_d = 1'b1; tx_data_d = CH_MINUS; end
      ST_SEND_DIG:  begin tx_valid_d = 1'b1; tx_data_d = CH_ZERO + {4'h0, bcd[{ptr_d, 2'b00} +: 4]}; end
      ST_SEND_CR:   begin tx_valid_d = 1'b1; tx_data_d = CH_CR; end
      ST_SEND_LF:   begin tx_valid_d = 1'b1; tx_data_d = CH_LF; end
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_res_ascii_tx.sv
// Bench for res_ascii_tx: directed and random results against a string-formatting model.
module tb_res_ascii_tx;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] res_in;
  logic        rv_s, rv_u;
  logic        tx_ready;
  logic [7:0]  tx_data_s, tx_data_u;
  logic        tx_valid_s, tx_valid_u, busy_s, busy_u;

  bit          cur_uns;
  logic [7:0]  obs_data;
  logic        obs_valid, obs_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  res_ascii_tx #(.SIGNED(1'b1), .EOL(1'b1)) dut_s (
    .clk(clk), .n_rst(n_rst), .res_in(res_in), .res_valid(rv_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready), .busy(busy_s));

  res_ascii_tx #(.SIGNED(1'b0), .EOL(1'b1)) dut_u (
    .clk(clk), .n_rst(n_rst), .res_in(res_in), .res_valid(rv_u),
    .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready), .busy(busy_u));

  assign obs_data  = cur_uns ? tx_data_u  : tx_data_s;
  assign obs_valid = cur_uns ? tx_valid_u : tx_valid_s;
  assign obs_busy  = cur_uns ? busy_u     : busy_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal text of the value as the selected interpretation, then CR LF.
  task automatic build_exp(input logic [31:0] val, input bit uns);
    longint v;
    string  s;
    v = uns ? longint'({32'd0, val}) : longint'($signed(val));
    s = $sformatf("%0d", v);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at a negedge; returns at the negedge right after the first byte is presented.
  task automatic capture(input logic [31:0] val, input bit uns);
    cur_uns  = uns;
    res_in   = val;
    rv_u     = uns;
    rv_s     = !uns;
    tx_ready = 1'b0;
    @(negedge clk);
    rv_u = 1'b0;
    rv_s = 1'b0;
    check("busy_rise", obs_busy, 1);
    check("valid_in_conv", obs_valid, 0);
    repeat (32) @(negedge clk);
    check("valid_before_33", obs_valid, 0);
    @(negedge clk);
    check("first_valid_at_33", obs_valid, 1);
  endtask

  // mode 0: ready=1, 1: toggling, 2: random
  task automatic drain(input int mode, input int max_bytes, input bit extra);
    int         guard;
    logic       prev_stall;
    logic [7:0] prev_data;
    guard = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    got_q.delete();
    while (got_q.size() < max_bytes && guard < 300) begin
      if (prev_stall) begin
        check("stall_valid_hold", obs_valid, 1);
        check("stall_data_hold", obs_data, prev_data);
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (guard == 0) ? 1'b0 : ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      rv_u = extra && cur_uns && (guard == 3);
      rv_s = extra && !cur_uns && (guard == 3);
      if (guard == 3) res_in = $urandom;
      prev_stall = obs_valid && !tx_ready;
      prev_data  = obs_data;
      if (obs_valid && tx_ready) got_q.push_back(obs_data);
      if (got_q.size() < max_bytes) begin
        @(negedge clk);
        guard++;
      end
    end
    rv_u = 1'b0;
    rv_s = 1'b0;
    if (guard >= 300) check("drain_timeout", 32'(got_q.size()), 32'(max_bytes));
  endtask

  task automatic finish_and_compare();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("busy_fall", obs_busy, 0);
    check("valid_fall", obs_valid, 0);
    check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
  endtask

  task automatic run_case(input logic [31:0] val, input bit uns, input int mode, input bit extra);
    build_exp(val, uns);
    capture(val, uns);
    drain(mode, exp_q.size(), extra);
    finish_and_compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] rv;
    n_rst = 1'b0; res_in = '0; rv_s = 1'b0; rv_u = 1'b0; tx_ready = 1'b0; cur_uns = 1'b0;
    @(negedge clk);
    check("rst_valid_s", tx_valid_s, 0);
    check("rst_data_s", tx_data_s, 0);
    check("rst_busy_s", busy_s, 0);
    check("rst_busy_u", busy_u, 0);
    n_rst = 1'b1;
    @(negedge clk);

    run_case(32'h0000_0000, 1'b0, 0, 1'b0);
    run_case(32'hFFFF_FFFA, 1'b0, 0, 1'b0);
    run_case(32'h8000_0000, 1'b0, 0, 1'b0);
    run_case(32'h7FFF_FFFF, 1'b0, 1, 1'b0);
    run_case(32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (obs_valid) seen++;
    end
    check("no_extra_output", 32'(seen), 0);

    // Abort "-123" while its third byte is presented.
    build_exp(32'hFFFF_FF85, 1'b0);
    capture(32'hFFFF_FF85, 1'b0);
    drain(0, 2, 1'b0);
    tx_ready = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_valid", tx_valid_s, 0);
    check("async_rst_data", tx_data_s, 0);
    check("async_rst_busy", busy_s, 0);
    check("abort_byte0", got_q[0], 8'h2D);
    check("abort_byte1", got_q[1], 8'h31);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_valid_s || busy_s) seen++;
    end
    check("no_resume", 32'(seen), 0);
    run_case(32'h0000_0064, 1'b0, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      rv = (n % 2 == 0) ? $urandom : (32'($urandom_range(0, 30)) - 32'd15);
      run_case(rv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
